ddr_init_seq: RTL and testbench

DDR_INIT_SEQ -- requirements
Module: ddr_init_seq

---
 rtl/ddr_init_seq.sv | 160 ++++++++++++++++
 tb/tb_ddr_init_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
// SDRAM power-up initialization sequencer: waits for a stable clock lock, then
// runs the precharge / mode-load / refresh sequence and holds NOP with init_done.
module ddr_init_seq #(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned PWRUP_CYCLES = 200,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned T_RFC        = 8,
    parameter logic [12:0] MODE_REG     = 13'h0022,
    parameter logic [12:0] EMODE_REG    = 13'h0000
) (
    input  logic        sim_clk,
    input  logic        rst,
    input  logic        dcm_lock,
    output logic        cke,
    output logic [3:0]  cmd,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic        init_done,
    output logic        lock_lost
);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [3:0] {
        S_WAIT_LOCK, S_STABLE, S_PWRUP, S_PRE1, S_EMR, S_MR_DLL,
        S_PRE2, S_REF1, S_REF2, S_MR, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cke_q, cke_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [12:0] addr_q, addr_d;
    logic        init_done_q, init_done_d;
    logic        lock_lost_q, lock_lost_d;

    // The WAIT_LOCK sample already counts as the first high, so STABLE needs LOCK_STABLE-1 more.
    function automatic logic [15:0] reload(input state_t s);
        case (s)
            S_STABLE:            reload = (LOCK_STABLE >= 2) ? 16'(LOCK_STABLE - 2) : 16'd0;
            S_PWRUP:             reload = 16'(PWRUP_CYCLES - 1);
            S_PRE1, S_PRE2:      reload = 16'(T_RP - 1);
            S_EMR, S_MR_DLL, S_MR: reload = 16'(T_MRD - 1);
            S_REF1, S_REF2:      reload = 16'(T_RFC - 1);
            default:             reload = 16'd0;
        endcase
    endfunction

    function automatic state_t seq_next(input state_t s);
        case (s)
            S_PWRUP:  seq_next = S_PRE1;
            S_PRE1:   seq_next = S_EMR;
            S_EMR:    seq_next = S_MR_DLL;
            S_MR_DLL: seq_next = S_PRE2;
            S_PRE2:   seq_next = S_REF1;
            S_REF1:   seq_next = S_REF2;
            S_REF2:   seq_next = S_MR;
            default:  seq_next = S_DONE;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = lock_lost_q;
        case (state_q)
            S_WAIT_LOCK: begin
                if (dcm_lock) state_d = (LOCK_STABLE <= 1) ? S_PWRUP : S_STABLE;
            end
            S_STABLE: begin
                if (!dcm_lock)       state_d = S_WAIT_LOCK;
                else if (cnt_q == 0) state_d = S_PWRUP;
                else                 cnt_d = cnt_q - 16'd1;
            end
            S_DONE: begin
                if (!dcm_lock) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end
            end
            default: begin
                if (!dcm_lock) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (cnt_q == 0) begin
                    state_d = seq_next(state_q);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
        if (state_d != state_q) cnt_d = reload(state_d);

        // Outputs decode the upcoming state so they are registered alongside it.
        cke_d       = (state_d >= S_PWRUP);
        init_done_d = (state_d == S_DONE);
        cmd_d       = (state_d >= S_PWRUP) ? CMD_NOP : CMD_DESEL;
        ba_d        = 2'b00;
        addr_d      = 13'd0;
        if (state_d != state_q) begin
            case (state_d)
                S_PRE1, S_PRE2: begin
                    cmd_d  = CMD_PRE;
                    addr_d = 13'h0400;
                end
                S_EMR: begin
                    cmd_d  = CMD_LMR;
                    ba_d   = 2'b01;
                    addr_d = EMODE_REG;
                end
                S_MR_DLL: begin
                    cmd_d  = CMD_LMR;
                    addr_d = MODE_REG | 13'h0100;
                end
                S_REF1, S_REF2: cmd_d = CMD_REF;
                S_MR: begin
                    cmd_d  = CMD_LMR;
                    addr_d = MODE_REG & ~13'h0100;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sim_clk) begin
        if (rst) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= 16'd0;
            cke_q       <= 1'b0;
            cmd_q       <= CMD_DESEL;
            ba_q        <= 2'b00;
            addr_q      <= 13'd0;
            init_done_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cke_q       <= cke_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign cke       = cke_q;
    assign cmd       = cmd_q;
    assign ba        = ba_q;
    assign addr      = addr_q;
    assign init_done = init_done_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Bench for ddr_init_seq: a default instance and a minimum-spacing instance,
// checked every cycle against a command-schedule model plus vector tables.
module tb_ddr_init_seq;

    logic        sim_clk = 1'b0;
    logic        rst = 1'b1;
    logic        dcm_lock = 1'b0;
    logic        cke_m, done_m, lost_m, cke_f, done_f, lost_f;
    logic [3:0]  cmd_m, cmd_f;
    logic [1:0]  ba_m, ba_f;
    logic [12:0] addr_m, addr_f;

    always #5 sim_clk = ~sim_clk;

    ddr_init_seq dut_m (
        .sim_clk(sim_clk), .rst(rst), .dcm_lock(dcm_lock),
        .cke(cke_m), .cmd(cmd_m), .ba(ba_m), .addr(addr_m),
        .init_done(done_m), .lock_lost(lost_m)
    );

    ddr_init_seq #(
        .LOCK_STABLE(3), .PWRUP_CYCLES(5), .T_RP(1), .T_MRD(1), .T_RFC(1)
    ) dut_f (
        .sim_clk(sim_clk), .rst(rst), .dcm_lock(dcm_lock),
        .cke(cke_f), .cmd(cmd_f), .ba(ba_f), .addr(addr_f),
        .init_done(done_f), .lock_lost(lost_f)
    );

    int errors = 0;
    int checks = 0;

    // Per-instance parameters: index 0 = defaults, index 1 = minimum spacing.
    int p_ls[2]   = '{16, 3};
    int p_pw[2]   = '{200, 5};
    int p_rp[2]   = '{2, 1};
    int p_mrd[2]  = '{2, 1};
    int p_rfc[2]  = '{8, 1};

    // Model state: run = consecutive high samples while waiting; t = cycles since cke rose (-1 = idle).
    int run[2] = '{0, 0};
    int t[2]   = '{-1, -1};
    bit lost[2] = '{1'b0, 1'b0};

    function automatic logic [21:0] pk(input bit c, input logic [3:0] cm, input logic [1:0] b,
                                       input logic [12:0] a, input bit d, input bit l);
        return {c, cm, b, a, d, l};
    endfunction

    function automatic logic [21:0] dut_out(input int idx);
        if (idx == 0) return {cke_m, cmd_m, ba_m, addr_m, done_m, lost_m};
        return {cke_f, cmd_f, ba_f, addr_f, done_f, lost_f};
    endfunction

    function automatic logic [21:0] model_out(input int idx);
        int off[8];
        logic [3:0]  c;
        logic [1:0]  b;
        logic [12:0] a;
        if (t[idx] < 0) return pk(1'b0, 4'hF, 2'd0, 13'd0, 1'b0, lost[idx]);
        off[0] = p_pw[idx];
        off[1] = off[0] + p_rp[idx];
        off[2] = off[1] + p_mrd[idx];
        off[3] = off[2] + p_mrd[idx];
        off[4] = off[3] + p_rp[idx];
        off[5] = off[4] + p_rfc[idx];
        off[6] = off[5] + p_rfc[idx];
        off[7] = off[6] + p_mrd[idx];
        c = 4'h7; b = 2'd0; a = 13'd0;
        if (t[idx] == off[0] || t[idx] == off[3]) begin c = 4'h2; a = 13'h0400; end
        if (t[idx] == off[1]) begin c = 4'h0; b = 2'd1; a = 13'h0000; end
        if (t[idx] == off[2]) begin c = 4'h0; a = 13'h0122; end
        if (t[idx] == off[4] || t[idx] == off[5]) c = 4'h1;
        if (t[idx] == off[6]) begin c = 4'h0; a = 13'h0022; end
        return pk(1'b1, c, b, a, t[idx] >= off[7], lost[idx]);
    endfunction

    function automatic void model_step(input int idx, input bit r, input bit l);
        if (r) begin
            run[idx] = 0; t[idx] = -1; lost[idx] = 1'b0;
        end else if (t[idx] >= 0) begin
            if (!l) begin t[idx] = -1; run[idx] = 0; lost[idx] = 1'b1; end
            else if (t[idx] < 100000) t[idx]++;
        end else if (l) begin
            run[idx]++;
            if (run[idx] >= p_ls[idx]) begin t[idx] = 0; run[idx] = 0; end
        end else begin
            run[idx] = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got cke=%0b cmd=%h ba=%0d addr=%h done=%0b lost=%0b, need cke=%0b cmd=%h ba=%0d addr=%h done=%0b lost=%0b",
                         name, got[21], got[20:17], got[16:15], got[14:2], got[1], got[0],
                         exp[21], exp[20:17], exp[16:15], exp[14:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input bit r, input bit l);
        rst = r;
        dcm_lock = l;
        @(posedge sim_clk);
        model_step(0, r, l);
        model_step(1, r, l);
        #1;
        chk("model_default", dut_out(0), model_out(0));
        chk("model_fast", dut_out(1), model_out(1));
    endtask

    task automatic hold(input bit r, input bit l, input int n);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    typedef struct {
        bit          rst;
        bit          lock;
        int          n;
        logic [21:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[18];
    logic [21:0] fast_cmds[7];

    initial begin
        vecs[0]  = '{1, 0, 3,   pk(0, 4'hF, 0, 13'h000, 0, 0), "reset"};
        vecs[1]  = '{0, 1, 15,  pk(0, 4'hF, 0, 13'h000, 0, 0), "lock_15"};
        vecs[2]  = '{0, 1, 1,   pk(1, 4'h7, 0, 13'h000, 0, 0), "cke_rise"};
        vecs[3]  = '{0, 1, 199, pk(1, 4'h7, 0, 13'h000, 0, 0), "pwrup_end"};
        vecs[4]  = '{0, 1, 1,   pk(1, 4'h2, 0, 13'h400, 0, 0), "pre1"};
        vecs[5]  = '{0, 1, 1,   pk(1, 4'h7, 0, 13'h000, 0, 0), "nop_after_pre1"};
        vecs[6]  = '{0, 1, 1,   pk(1, 4'h0, 1, 13'h000, 0, 0), "emr"};
        vecs[7]  = '{0, 1, 2,   pk(1, 4'h0, 0, 13'h122, 0, 0), "mr_dll"};
        vecs[8]  = '{0, 1, 2,   pk(1, 4'h2, 0, 13'h400, 0, 0), "pre2"};
        vecs[9]  = '{0, 1, 2,   pk(1, 4'h1, 0, 13'h000, 0, 0), "ref1"};
        vecs[10] = '{0, 1, 8,   pk(1, 4'h1, 0, 13'h000, 0, 0), "ref2"};
        vecs[11] = '{0, 1, 8,   pk(1, 4'h0, 0, 13'h022, 0, 0), "mr"};
        vecs[12] = '{0, 1, 1,   pk(1, 4'h7, 0, 13'h000, 0, 0), "before_done"};
        vecs[13] = '{0, 1, 1,   pk(1, 4'h7, 0, 13'h000, 1, 0), "done"};
        vecs[14] = '{0, 1, 50,  pk(1, 4'h7, 0, 13'h000, 1, 0), "done_hold"};
        vecs[15] = '{0, 0, 1,   pk(0, 4'hF, 0, 13'h000, 0, 1), "lock_drop"};
        vecs[16] = '{0, 0, 5,   pk(0, 4'hF, 0, 13'h000, 0, 1), "lost_sticky"};
        vecs[17] = '{1, 0, 1,   pk(0, 4'hF, 0, 13'h000, 0, 0), "rst_clears"};

        fast_cmds[0] = pk(1, 4'h2, 0, 13'h400, 0, 0);
        fast_cmds[1] = pk(1, 4'h0, 1, 13'h000, 0, 0);
        fast_cmds[2] = pk(1, 4'h0, 0, 13'h122, 0, 0);
        fast_cmds[3] = pk(1, 4'h2, 0, 13'h400, 0, 0);
        fast_cmds[4] = pk(1, 4'h1, 0, 13'h000, 0, 0);
        fast_cmds[5] = pk(1, 4'h1, 0, 13'h000, 0, 0);
        fast_cmds[6] = pk(1, 4'h0, 0, 13'h022, 0, 0);

        for (int v = 0; v < 18; v++) begin
            hold(vecs[v].rst, vecs[v].lock, vecs[v].n);
            chk(vecs[v].name, dut_out(0), vecs[v].exp);
        end

        // Glitch in lock while stabilising restarts the count.
        hold(1, 0, 2);
        hold(0, 1, 10);
        hold(0, 0, 1);
        hold(0, 1, 15);
        chk("glitch_no_cke", dut_out(0), pk(0, 4'hF, 0, 13'h000, 0, 0));
        hold(0, 1, 1);
        chk("glitch_cke", dut_out(0), pk(1, 4'h7, 0, 13'h000, 0, 0));

        // Lock loss right after REF1, then a full replay.
        hold(0, 1, 208);
        chk("at_ref1", dut_out(0), pk(1, 4'h1, 0, 13'h000, 0, 0));
        hold(0, 0, 1);
        chk("ref1_drop", dut_out(0), pk(0, 4'hF, 0, 13'h000, 0, 1));
        hold(0, 1, 16 + 226);
        chk("relock_done", dut_out(0), pk(1, 4'h7, 0, 13'h000, 1, 1));

        // Reset in the middle of power-up.
        hold(0, 1, 30);
        hold(1, 1, 1);
        chk("rst_pwrup", dut_out(0), pk(0, 4'hF, 0, 13'h000, 0, 0));
        hold(0, 1, 16);
        chk("rst_restart", dut_out(0), pk(1, 4'h7, 0, 13'h000, 0, 0));

        // Minimum spacing: seven back-to-back commands then init_done.
        hold(1, 1, 1);
        hold(0, 1, 8);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("fast_cmd%0d", k), dut_out(1), fast_cmds[k]);
            hold(0, 1, 1);
        end
        chk("fast_done", dut_out(1), pk(1, 4'h7, 0, 13'h000, 1, 0));

        // Random lock drops and resets.
        hold(1, 0, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 999) == 0, $urandom_range(0, 299) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
